// File: rtl/ext_bus_responder.sv
// External-bus slave: synchronizes multiplexed-bus strobes, latches the address and
// sequences reads/writes to a backing store. Define XBUS_WRITE_EN to build the write path.
module ext_bus_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ale,
  input  logic        psen_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  p0_in,
  input  logic [7:0]  p2_in,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        mem_code,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        bus_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] READY   = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] DRIVE   = 3'd5;
`ifdef XBUS_WRITE_EN
  localparam logic [2:0] WR_CAP  = 3'd6;
`endif

  logic [SYNC_STAGES-1:0] ale_sy, psen_sy, rd_sy, wr_sy;
  logic       psen_d, rd_d;
  logic [7:0] p0_q, p2_q;
  logic [2:0] state;
  logic       oe_q, rd_en_q;
  logic       ale_s, psen_s, rd_s, wr_s;
  logic       psen_fall, rd_fall, conflict;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ale_sy  <= '0;
      psen_sy <= '1;
      rd_sy   <= '1;
      wr_sy   <= '1;
      psen_d  <= 1'b1;
      rd_d    <= 1'b1;
      p0_q    <= 8'h00;
      p2_q    <= 8'h00;
    end else begin
      ale_sy  <= {ale_sy[SYNC_STAGES-2:0], ale};
      psen_sy <= {psen_sy[SYNC_STAGES-2:0], psen_n};
      rd_sy   <= {rd_sy[SYNC_STAGES-2:0], rd_n};
      wr_sy   <= {wr_sy[SYNC_STAGES-2:0], wr_n};
      psen_d  <= psen_s;
      rd_d    <= rd_s;
      p0_q    <= p0_in;
      p2_q    <= p2_in;
    end
  end

  assign ale_s     = ale_sy[SYNC_STAGES-1];
  assign psen_s    = psen_sy[SYNC_STAGES-1];
  assign rd_s      = rd_sy[SYNC_STAGES-1];
  assign wr_s      = wr_sy[SYNC_STAGES-1];
  assign psen_fall = psen_d & ~psen_s;
  assign rd_fall   = rd_d & ~rd_s;
  assign conflict  = (~psen_s & ~rd_s) | (~psen_s & ~wr_s) | (~rd_s & ~wr_s);

`ifdef XBUS_WRITE_EN
  logic       wr_en_q;
  logic [7:0] wr_data_q;
  assign mem_wr_en   = wr_en_q & ~conflict;
  assign mem_wr_data = wr_data_q;
`else
  assign mem_wr_en   = 1'b0;
  assign mem_wr_data = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      p0_out   <= 8'h00;
      oe_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      mem_code <= 1'b0;
      mem_addr <= 16'h0000;
      bus_err  <= 1'b0;
`ifdef XBUS_WRITE_EN
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
`endif
    end else begin
      rd_en_q <= 1'b0;
`ifdef XBUS_WRITE_EN
      wr_en_q <= 1'b0;
`endif
      if (state == ADDR) mem_addr <= {p2_q, p0_q};
      // Conflict outranks everything, then an address phase aborts any access.
      if (conflict) begin
        bus_err <= 1'b1;
        oe_q    <= 1'b0;
        state   <= IDLE;
      end else if (ale_s) begin
        oe_q  <= 1'b0;
        state <= ADDR;
      end else begin
        case (state)
          ADDR: state <= READY;
          READY: begin
            if (psen_fall) begin
              state    <= RD_REQ;
              mem_code <= 1'b1;
              rd_en_q  <= 1'b1;
            end else if (rd_fall) begin
              state    <= RD_REQ;
              mem_code <= 1'b0;
              rd_en_q  <= 1'b1;
            end
`ifdef XBUS_WRITE_EN
            else if (!wr_s) begin
              state     <= WR_CAP;
              wr_data_q <= p0_q;
            end
`endif
          end
          RD_REQ: state <= RD_WAIT;
          RD_WAIT: begin
            p0_out <= mem_rd_data;
            oe_q   <= 1'b1;
            state  <= DRIVE;
          end
          DRIVE: begin
            // Level test so a strobe released before DRIVE still ends the cycle.
            if (mem_code ? psen_s : rd_s) begin
              oe_q  <= 1'b0;
              state <= READY;
            end
          end
`ifdef XBUS_WRITE_EN
          WR_CAP: begin
            if (!wr_s) begin
              wr_data_q <= p0_q;
            end else begin
              wr_en_q  <= 1'b1;
              mem_code <= 1'b0;
              state    <= READY;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en = rd_en_q & ~conflict;
  assign p0_oe     = oe_q & ~ale_s & ~conflict;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: random bus transactions against a transaction-level
// model of the address space; XBUS_WRITE_EN selects the expected write behaviour.
module tb_ext_bus_responder;
  localparam int SS = 2;
`ifdef XBUS_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, ale = 1'b0;
  logic        psen_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  p0_in = 8'h00, p2_in = 8'h00, mem_rd_data = 8'h00;
  logic [7:0]  p0_out, mem_wr_data;
  logic        p0_oe, mem_rd_en, mem_wr_en, mem_code, bus_err;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  ext_bus_responder #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
    .p0_in(p0_in), .p2_in(p2_in), .p0_out(p0_out), .p0_oe(p0_oe),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_code(mem_code),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .bus_err(bus_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing store (environment) and the model's own view of memory contents.
  logic [7:0] code_store[int], data_store[int], model_code[int], model_data[int];

  function automatic logic [7:0] init_val(input int a, input bit code);
    int v;
    v = a * 37 + (a >> 8) * 11 + (code ? 90 : 0);
    return v[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] store_rd(input int a, input bit code);
    if (code) return code_store.exists(a) ? code_store[a] : init_val(a, 1'b1);
    return data_store.exists(a) ? data_store[a] : init_val(a, 1'b0);
  endfunction

  function automatic logic [7:0] model_rd(input int a, input bit code);
    if (code) return model_code.exists(a) ? model_code[a] : init_val(a, 1'b1);
    return model_data.exists(a) ? model_data[a] : init_val(a, 1'b0);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= store_rd(int'(mem_addr), mem_code);
    if (mem_wr_en) data_store[int'(mem_addr)] = mem_wr_data;
  end

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_cyc = -100, oe_rise = -100, ale_hi = 0;
  logic oe_prev = 1'b0;
  logic [7:0] wr_seen = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (mem_rd_en) begin rd_cnt++; rd_cyc = cyc; end
    if (mem_wr_en) begin wr_cnt++; wr_seen = mem_wr_data; end
    if (p0_oe && !oe_prev) oe_rise = cyc;
    oe_prev = p0_oe;
    ale_hi = ale ? ale_hi + 1 : 0;
    if (ale_hi > SS) chk("oe_during_ale", 32'(p0_oe), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_p0_out"}, 32'(p0_out), 32'd0);
    chk({tag, "_p0_oe"}, 32'(p0_oe), 32'd0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_code"}, 32'(mem_code), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic latch_addr(input logic [15:0] a);
    ale = 1'b1; p2_in = a[15:8]; p0_in = a[7:0];
    tick(SS + 1);
    ale = 1'b0;
    tick(SS + 2);
    chk("addr_latch", 32'(mem_addr), 32'(a));
    p2_in = 8'($urandom); p0_in = 8'($urandom);
    tick(3);
    chk("addr_hold", 32'(mem_addr), 32'(a));
  endtask

  task automatic do_read(input logic [15:0] a, input bit code, input string tag);
    int rd0, k;
    logic [7:0] exp;
    exp = model_rd(int'(a), code);
    rd0 = rd_cnt;
    if (code) psen_n = 1'b0; else rd_n = 1'b0;
    k = 0;
    while (!p0_oe && k < 20) begin tick(1); k++; end
    chk({tag, "_oe_on"}, 32'(p0_oe), 32'd1);
    tick(1);
    chk({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'd1);
    chk({tag, "_code"}, 32'(mem_code), 32'(code));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_oe_lat"}, 32'(oe_rise - rd_cyc), 32'd2);
    chk({tag, "_data"}, 32'(p0_out), 32'(exp));
    if (code) psen_n = 1'b1; else rd_n = 1'b1;
    k = 0;
    do begin tick(1); k++; end while (p0_oe && k < 20);
    chk({tag, "_oe_off_lat"}, 32'(k), 32'(SS + 1));
    chk({tag, "_data_hold"}, 32'(p0_out), 32'(exp));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int wr0;
    wr0 = wr_cnt;
    wr_n = 1'b0; p0_in = d;
    tick(4);
    wr_n = 1'b1;
    tick(SS + 4);
    chk("wr_pulses", 32'(wr_cnt - wr0), WEN ? 32'd1 : 32'd0);
    if (WEN) begin
      chk("wr_data", 32'(wr_seen), 32'(d));
      chk("wr_code", 32'(mem_code), 32'd0);
      model_data[int'(a)] = d;
    end else begin
      chk("wr_data_tied", 32'(mem_wr_data), 32'd0);
    end
    p0_in = 8'($urandom);
  endtask

  initial begin
    int rd0, k;
    logic [15:0] a, b;
    logic [7:0] d;

    #2;
    check_reset_outs("rst_async");
    tick(2);
    rst = 1'b1;
    tick(2);
    check_reset_outs("post_rst");

    rd0 = rd_cnt;
    psen_n = 1'b0;
    tick(10);
    chk("idle_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("idle_no_oe", 32'(p0_oe), 32'd0);
    psen_n = 1'b1;
    tick(4);

    code_store[32'h1234] = 8'hA5; model_code[32'h1234] = 8'hA5;
    data_store[32'hFFFF] = 8'h5A; model_data[32'hFFFF] = 8'h5A;
    latch_addr(16'h1234);
    do_read(16'h1234, 1'b1, "code_1234");
    latch_addr(16'hFFFF);
    do_read(16'hFFFF, 1'b0, "data_ffff");
    latch_addr(16'h0000);
    latch_addr(16'h8001);
    do_write(16'h8001, 8'hC3);
    do_read(16'h8001, 1'b0, "rb_8001");

    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      latch_addr(a);
      case ($urandom_range(0, 2))
        0: do_read(a, 1'b1, "rnd_code");
        1: do_read(a, 1'b0, "rnd_data");
        default: begin
          d = 8'($urandom);
          do_write(a, d);
          do_read(a, 1'b0, "rnd_rb");
        end
      endcase
    end

    // Address phase arriving while the read data is being driven.
    a = 16'($urandom);
    latch_addr(a);
    rd0 = rd_cnt;
    psen_n = 1'b0;
    k = 0;
    while (!p0_oe && k < 20) begin tick(1); k++; end
    chk("abort_oe_on", 32'(p0_oe), 32'd1);
    b = 16'($urandom);
    ale = 1'b1; p2_in = b[15:8]; p0_in = b[7:0];
    k = 0;
    do begin tick(1); k++; end while (p0_oe && k < 10);
    chk("abort_oe_lat_ok", 32'(k <= SS + 1), 32'd1);
    tick(SS + 2);
    chk("abort_track", 32'(mem_addr), 32'(b));
    ale = 1'b0;
    tick(SS + 2);
    psen_n = 1'b1;
    tick(4);
    chk("abort_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    chk("abort_oe_off", 32'(p0_oe), 32'd0);

    latch_addr(16'($urandom));
    rd0 = rd_cnt;
    psen_n = 1'b0; rd_n = 1'b0;
    tick(10);
    chk("conf_bus_err", 32'(bus_err), 32'd1);
    chk("conf_oe", 32'(p0_oe), 32'd0);
    chk("conf_no_rd", 32'(rd_cnt - rd0), 32'd0);
    psen_n = 1'b1; rd_n = 1'b1;
    latch_addr(16'($urandom));
    tick(5);
    chk("conf_sticky", 32'(bus_err), 32'd1);

    a = 16'($urandom);
    latch_addr(a);
    psen_n = 1'b0;
    k = 0;
    while (!mem_rd_en && k < 20) begin tick(1); k++; end
    chk("rdw_req_seen", 32'(mem_rd_en), 32'd1);
    tick(1);
    rst = 1'b0;
    #1;
    check_reset_outs("rst_rdwait");
    tick(3);
    rd0 = rd_cnt;
    rst = 1'b1;
    tick(6);
    chk("rel_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("rel_no_oe", 32'(p0_oe), 32'd0);
    psen_n = 1'b1;
    tick(4);

    latch_addr(16'($urandom));
    rd_n = 1'b0;
    k = 0;
    while (!p0_oe && k < 20) begin tick(1); k++; end
    chk("drv_oe_on", 32'(p0_oe), 32'd1);
    rst = 1'b0;
    #1;
    chk("drv_rst_oe", 32'(p0_oe), 32'd0);
    chk("drv_rst_out", 32'(p0_out), 32'd0);
    rd_n = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_bus_responder.md
EXT_BUS_RESPONDER -- requirements
Module: ext_bus_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on each input strobe (ale, psen_n, rd_n, wr_n); legal values are 2 and 3.
REQ-002 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-003 rst  input  1  asynchronous reset, SHALL be active-low.
REQ-004 ale  input  1  address latch enable from the bus master.
REQ-005 psen_n  input  1  program store enable, active-low code read strobe.
REQ-006 rd_n  input  1  external data read strobe, active-low.
REQ-007 wr_n  input  1  external data write strobe, active-low.
REQ-008 p0_in  input  8  multiplexed low address / data bus sampled value.
REQ-009 p2_in  input  8  high address bus sampled value.
REQ-010 p0_out  output  8  read data driven toward the master.
REQ-011 p0_oe  output  1  p0 output enable, active-high.
REQ-012 mem_rd_en  output  1  one-cycle read request to the backing store.
REQ-013 mem_wr_en  output  1  one-cycle write request to the backing store.
REQ-014 mem_code  output  1  1 = code space (psen_n access), 0 = data space.
REQ-015 mem_addr  output  16  latched {p2, p0} address.
REQ-016 mem_wr_data  output  8  write data.
REQ-017 mem_rd_data  input  8  backing store data, valid one cycle after mem_rd_en.
REQ-018 bus_err  output  1  sticky conflict flag.

Function
REQ-019 Strobes SHALL be synchronized through SYNC_STAGES flops; edges SHALL be detected on the synchronized values only; p0_in/p2_in SHALL be registered once.
REQ-020 States SHALL be IDLE, ADDR, READY, RD_REQ, RD_WAIT, DRIVE, WR_CAP.
REQ-021 Any state, synchronized ale high -> ADDR; while in ADDR, mem_addr SHALL track {p2_in, p0_in} registered each cycle.
REQ-022 ADDR, ale falling edge -> READY; mem_addr SHALL then hold until the next ADDR.
REQ-023 READY, psen_n or rd_n falling edge (cycle N) -> RD_REQ; mem_code SHALL be 1 for psen_n, 0 for rd_n.
REQ-024 mem_rd_en SHALL be high exactly in cycle N+1 (RD_REQ); RD_WAIT in N+2 captures mem_rd_data into p0_out; p0_oe SHALL be high from N+3 (DRIVE).
REQ-025 DRIVE, active strobe rising edge -> READY; p0_oe SHALL deassert in the following cycle; p0_out SHALL hold its value.
REQ-026 READY, wr_n low: p0_in registered value SHALL be copied to mem_wr_data every cycle (WR_CAP); wr_n rising edge -> mem_wr_en high one cycle, mem_code 0, then READY.
REQ-027 Two or more of psen_n, rd_n, wr_n simultaneously low (synchronized) SHALL set bus_err, force p0_oe 0, suppress mem_rd_en/mem_wr_en, and go to IDLE; bus_err clears only on reset.
REQ-028 ale high during RD_REQ/RD_WAIT/DRIVE/WR_CAP SHALL abort: p0_oe 0 next cycle, pending mem_wr_en suppressed, state ADDR.
REQ-029 Strobe falling edge in IDLE (no address latched since reset or error) SHALL be ignored; p0_oe stays 0.
REQ-030 p0_oe SHALL never be high in any cycle where synchronized ale is high.

Reset
REQ-031 rst low SHALL immediately force state IDLE, all synchronizer flops to idle levels (ale 0, strobes 1), p0_out 0x00, p0_oe 0, mem_rd_en 0, mem_wr_en 0, mem_code 0, mem_addr 0x0000, mem_wr_data 0x00, bus_err 0.
REQ-032 Reset asserted mid-access SHALL drop p0_oe asynchronously; no memory request SHALL issue in the cycle reset is released.

Configuration
REQ-033 Macro XBUS_WRITE_EN defined: write path per REQ-026 present.
REQ-034 XBUS_WRITE_EN undefined: WR_CAP omitted, wr_n ignored except for REQ-027 conflict checking, mem_wr_en and mem_wr_data tied 0.

Verification
REQ-035 ale pulse with p2=0x12, p0=0x34, then psen_n low; store returns 0xA5 -> mem_addr 0x1234, mem_code 1, mem_rd_en one pulse, p0_out 0xA5, p0_oe high N+3 until psen_n rise +1.
REQ-036 Address 0xFFFF latched, rd_n read, store returns 0x5A -> mem_code 0, p0_out 0x5A; next ale with 0x0000 latches 0x0000 (no carry artefacts).
REQ-037 XBUS_WRITE_EN defined, address 0x8001, wr_n low with p0=0xC3 -> one mem_wr_en pulse after wr_n rise, mem_wr_data 0xC3; undefined -> no pulse.
REQ-038 psen_n and rd_n low together after ale -> bus_err 1, p0_oe 0, no mem_rd_en; persists until rst low.
REQ-039 ale rises while in DRIVE -> p0_oe 0 next cycle, new address tracked; rst low during RD_WAIT -> all outputs at reset values immediately.
REQ-040 psen_n low after reset without prior ale -> no mem_rd_en, p0_oe stays 0.
